// File: rtl/prefix_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters.
// A tag pipeline follows each operation through the adder; results land in a credit-protected response FIFO.
module prefix_sched #(
    parameter int NREQ  = 4,
    parameter int W     = 32,
    parameter int LAT   = 6,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_x,
    input  logic [NREQ*W-1:0]       req_y,
    input  logic [NREQ-1:0]         req_cin,
    output logic [W-1:0]            add_x,
    output logic [W-1:0]            add_y,
    output logic                    add_cin,
    input  logic [W-1:0]            add_s,
    input  logic                    add_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW  = $clog2(DEPTH + 1);
    localparam int EW  = IDW + W + 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] cand;
    logic           found;
    logic           credit;
    logic           issue;
    logic           pop;
    logic           wr;
    logic [OW-1:0]  occ;
    logic [LAT-1:0] tag_vld;
    logic [IDW-1:0] tag_id [LAT];
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  head;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [OW-1:0]  count;

    // First valid requester at or after ptr, wrapping around
    always_comb begin
        found = 1'b0;
        gid   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gid   = cand;
            end
        end
    end

    // occ counts in-flight plus queued results, so credit alone guarantees FIFO space on return
    assign credit = (occ < OW'(DEPTH));
    assign issue  = found && credit && !rst;

    always_comb begin
        req_ready = '0;
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;
        if (issue) begin
            req_ready[gid] = 1'b1;
            add_x          = req_x[int'(gid)*W +: W];
            add_y          = req_y[int'(gid)*W +: W];
            add_cin        = req_cin[gid];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (issue && !pop) begin
            occ <= occ + 1'b1;
        end else if (!issue && pop) begin
            occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_vld[0] <= issue;
            tag_id[0]  <= gid;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign wr        = tag_vld[LAT-1];
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)  wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop) rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            if (wr && !pop)      count <= count + 1'b1;
            else if (!wr && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= {tag_id[LAT-1], add_cout, add_s};
    end

    // Head fields are forced to zero while empty so stale entries never show after reset
    assign head     = mem[rptr];
    assign rsp_sum  = rsp_valid ? head[W-1:0]       : '0;
    assign rsp_cout = rsp_valid ? head[W]           : 1'b0;
    assign rsp_id   = rsp_valid ? head[W+1 +: IDW]  : '0;
    assign busy     = (occ != '0);

    assert property (@(posedge clk) disable iff (rst) !(wr && (count == OW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_prefix_sched.sv
// Directed bench for prefix_sched with a behavioural pipelined adder and an in-order response scoreboard.
module tb_prefix_sched;
    localparam int NREQ  = 4;
    localparam int W     = 32;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      add_x;
    logic [W-1:0]      add_y;
    logic              add_cin;
    logic [W-1:0]      add_s;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] sum;
        logic         cout;
        int           rdy;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         mptr   = 0;
    int         mocc   = 0;
    int         missue = 0;
    int         start;
    logic [W:0] apipe [LAT];

    prefix_sched #(.NREQ(NREQ), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External adder: never reset, so stale sums keep emerging after a DUT reset
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_s    = apipe[LAT-1][W-1:0];
    assign add_cout = apipe[LAT-1][W];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setOp(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_cin[i]      = c;
    endtask

    task automatic resetModel();
        q.delete();
        mptr = 0;
        mocc = 0;
    endtask

    // One clock: check outputs against the model, cross the edge, then advance the model
    task automatic applyStimulus();
        int              eg;
        logic            iss;
        logic            rv;
        logic [NREQ-1:0] er;
        logic [W:0]      s;
        exp_t            e;
        #1;
        eg = -1;
        for (int k = 0; k < NREQ; k++)
            if (eg < 0 && req_valid[(mptr + k) % NREQ]) eg = (mptr + k) % NREQ;
        iss = (eg >= 0) && (mocc < DEPTH);
        er  = '0;
        s   = '0;
        if (iss) er[eg] = 1'b1;
        checkOutput("req_ready", 64'(req_ready), 64'(er));
        rv = (q.size() != 0) && (q[0].rdy <= cyc);
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(rv));
        if (rv) begin
            checkOutput("rsp_id", 64'(rsp_id), 64'(q[0].id));
            checkOutput("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
            checkOutput("rsp_cout", 64'(rsp_cout), 64'(q[0].cout));
        end
        checkOutput("busy", 64'(busy), 64'(mocc != 0));
        if (iss) begin
            s = {1'b0, req_x[eg*W +: W]} + {1'b0, req_y[eg*W +: W]} + {{W{1'b0}}, req_cin[eg]};
            checkOutput("add_x", 64'(add_x), 64'(req_x[eg*W +: W]));
            checkOutput("add_y", 64'(add_y), 64'(req_y[eg*W +: W]));
            checkOutput("add_cin", 64'(add_cin), 64'(req_cin[eg]));
        end else begin
            checkOutput("add_idle", 64'({add_cin, add_x}), 64'(0));
        end
        @(posedge clk);
        cyc++;
        if (rv && rsp_ready) begin
            void'(q.pop_front());
            mocc--;
        end
        if (iss) begin
            e.id   = eg[1:0];
            e.sum  = s[W-1:0];
            e.cout = s[W];
            e.rdy  = cyc + LAT;
            q.push_back(e);
            mocc++;
            mptr = (eg + 1) % NREQ;
            missue++;
        end
        #1;
    endtask

    task automatic drain(input logic toggle);
        req_valid = '0;
        for (int n = 0; n < 200 && q.size() != 0; n++) begin
            if (toggle) rsp_ready = ~rsp_ready;
            applyStimulus();
        end
        rsp_ready = 1'b1;
        checkOutput("drain_done", 64'(q.size()), 64'(0));
        applyStimulus();
        checkOutput("drain_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_add", 64'({add_cin, add_x}), 64'(0));
        checkOutput("rst_rsp_data", 64'({rsp_id, rsp_cout, rsp_sum}), 64'(0));
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();

        // Single op from requester 2
        rsp_ready = 1'b1;
        setOp(2, 32'h0000FFFF, 32'h00000001, 1'b0);
        req_valid = 4'b0100;
        applyStimulus();
        req_valid = '0;
        repeat (LAT) applyStimulus();
        checkOutput("single_valid", 64'(rsp_valid), 64'(1));
        checkOutput("single_id", 64'(rsp_id), 64'(2));
        checkOutput("single_sum", 64'(rsp_sum), 64'(32'h00010000));
        checkOutput("single_cout", 64'(rsp_cout), 64'(0));
        applyStimulus();
        checkOutput("single_busy_drop", 64'(busy), 64'(0));

        // Round robin, pointer sits at 3 after the single op
        setOp(0, 32'h00000001, 32'h00000002, 1'b0);
        setOp(1, 32'h80000000, 32'h80000000, 1'b0);
        setOp(2, 32'h12345678, 32'h11111111, 1'b1);
        setOp(3, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        req_valid = '1;
        #1;
        checkOutput("rr_first_grant", 64'(req_ready), 64'(4'b1000));
        applyStimulus();
        repeat (LAT) applyStimulus();
        checkOutput("rr_first_id", 64'(rsp_id), 64'(3));
        checkOutput("rr_first_sum", 64'(rsp_sum), 64'(0));
        checkOutput("rr_first_cout", 64'(rsp_cout), 64'(1));
        repeat (8) applyStimulus();
        drain(1'b0);

        // Backpressure fills to DEPTH then stalls
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        for (int n = 0; n < 12; n++) begin
            setOp(0, 32'h10000000 + W'(n), W'(n * 3), n[0]);
            applyStimulus();
        end
        checkOutput("bp_stall", 64'(req_ready), 64'(0));
        checkOutput("bp_valid", 64'(rsp_valid), 64'(1));
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_no_same_cycle_credit", 64'(req_ready), 64'(0));
        applyStimulus();
        checkOutput("bp_resume", 64'(req_ready), 64'(1));
        repeat (3) applyStimulus();
        drain(1'b0);

        // Wrap-around with rsp_ready toggling
        start = missue;
        req_valid = 4'b0110;
        for (int n = 0; n < 200 && (missue - start) < 20; n++) begin
            rsp_ready = ~n[0];
            setOp(1, W'(n) * 32'h01010101, ~W'(n), 1'b0);
            setOp(2, 32'hFFFF0000 + W'(n), 32'h00010000, n[0]);
            applyStimulus();
        end
        checkOutput("wrap_issued", 64'(missue - start), 64'(20));
        drain(1'b1);

        // Simultaneous issue and pop with occ at DEPTH-1
        rsp_ready = 1'b0;
        start = missue;
        req_valid = 4'b0001;
        for (int n = 0; n < 20 && (missue - start) < DEPTH - 1; n++) begin
            setOp(0, 32'h000000A0 + W'(n), 32'h00000005, 1'b0);
            applyStimulus();
        end
        req_valid = '0;
        repeat (LAT + 1) applyStimulus();
        setOp(0, 32'hDEAD0000, 32'h0000BEEF, 1'b1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checkOutput("sim_ready", 64'(req_ready), 64'(1));
        checkOutput("sim_valid", 64'(rsp_valid), 64'(1));
        applyStimulus();
        rsp_ready = 1'b0;
        #1;
        checkOutput("sim_credit_kept", 64'(req_ready), 64'(1));
        applyStimulus();
        #1;
        checkOutput("sim_full", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        drain(1'b0);

        // Reset with five ops in flight
        setOp(0, 32'h11111111, 32'h1, 1'b0);
        setOp(1, 32'h22222222, 32'h2, 1'b0);
        setOp(2, 32'h33333333, 32'h3, 1'b0);
        setOp(3, 32'h44444444, 32'h4, 1'b0);
        req_valid = '1;
        repeat (5) applyStimulus();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 64'(req_ready), 64'(0));
        checkOutput("mid_rst_valid", 64'(rsp_valid), 64'(0));
        checkOutput("mid_rst_busy", 64'(busy), 64'(0));
        checkOutput("mid_rst_add", 64'({add_cin, add_x}), 64'(0));
        resetModel();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (LAT + 2) applyStimulus();
        setOp(1, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        req_valid = 4'b1010;
        #1;
        checkOutput("post_rst_grant", 64'(req_ready), 64'(4'b0010));
        applyStimulus();
        req_valid = '0;
        repeat (LAT) applyStimulus();
        checkOutput("post_rst_id", 64'(rsp_id), 64'(1));
        checkOutput("post_rst_sum", 64'(rsp_sum), 64'(32'h80000001));
        checkOutput("post_rst_cout", 64'(rsp_cout), 64'(0));
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
